line_window_buffer: RTL



---
 rtl/line_window_pkg.sv | 24 ++
 rtl/sdp_ram_1clk.sv | 26 ++
 rtl/line_window_buffer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/line_window_pkg.sv
// Shared types and helpers for the line window buffer.
// State encoding, address-width check and tap slicing.
package line_window_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam int LINE_CNT_W = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int tap_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/sdp_ram_1clk.sv
// Inferred simple dual-port RAM, one clock.
// One write port, one registered read port.
module sdp_ram_1clk
  import line_window_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 11,
  parameter int DEPTH      = 2048
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    if (re) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/line_window_buffer.sv
// Multi-line delay buffer: presents each pixel with the
// co-located pixels of the previous NUM_LINES-1 lines.
module line_window_buffer
  import line_window_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LINE_MAX   = 2048,
  parameter int ADDR_WIDTH = 11,
  parameter int NUM_LINES  = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_sof,
  input  logic                            in_valid,
  input  logic                            in_eol,
  input  logic [DATA_WIDTH-1:0]           in_data,
  output logic                            out_valid,
  output logic [NUM_LINES*DATA_WIDTH-1:0] out_taps,
  output logic [ADDR_WIDTH-1:0]           out_col,
  output logic                            out_window_ok,
  output logic                            err_overflow
);

  localparam logic [ADDR_WIDTH-1:0] COL_LAST =
    ADDR_WIDTH'(LINE_MAX - 1);
  localparam logic [LINE_CNT_W-1:0] LINE_FULL =
    LINE_CNT_W'(NUM_LINES - 1);

  if (ADDR_WIDTH != clog2(LINE_MAX)) begin : g_bad_aw
    $error("ADDR_WIDTH must equal clog2(LINE_MAX)");
  end
  if (NUM_LINES < 2 || NUM_LINES > 8) begin : g_bad_nl
    $error("NUM_LINES must be in 2..8");
  end

  state_t                  state;
  state_t                  state_nxt;
  logic                    accept_en;
  logic                    accept;
  logic                    at_last;
  logic                    ovf;
  logic                    err_nxt;
  logic [ADDR_WIDTH-1:0]   col;
  logic [ADDR_WIDTH-1:0]   col_base;
  logic [ADDR_WIDTH-1:0]   col_nxt;
  logic [LINE_CNT_W-1:0]   line_cnt;
  logic [LINE_CNT_W-1:0]   line_base;
  logic [LINE_CNT_W-1:0]   line_nxt;
  logic [DATA_WIDTH-1:0]   d_q;
  logic [NUM_LINES*DATA_WIDTH-1:0] taps_raw;

  // in_sof restarts the frame in the same cycle it arrives
  assign col_base  = in_sof ? '0 : col;
  assign line_base = in_sof ? '0 : line_cnt;
  assign accept    = in_valid & (accept_en | in_sof);
  assign at_last   = (col_base == COL_LAST);
  assign ovf       = accept & ~in_eol & at_last;
  assign err_nxt   = (err_overflow & ~in_sof) | ovf;

  always_comb begin
    col_nxt = col_base;
    if (accept) begin
      col_nxt = (in_eol | at_last) ? '0 : col_base + 1'b1;
    end
  end

  always_comb begin
    line_nxt = line_base;
    if (accept & in_eol & (line_base < LINE_FULL)) begin
      line_nxt = line_base + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (in_sof || state != ST_IDLE) begin
      state_nxt = (line_nxt >= LINE_FULL) ? ST_RUN : ST_FILL;
    end
  end

  always_comb begin
    accept_en = 1'b0;
    unique case (state)
      ST_FILL, ST_RUN: accept_en = 1'b1;
      default:         accept_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col          <= '0;
      line_cnt     <= '0;
      err_overflow <= 1'b0;
    end else begin
      col          <= col_nxt;
      line_cnt     <= line_nxt;
      err_overflow <= err_nxt;
    end
  end

  // out_col doubles as the delayed RAM write address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_col       <= '0;
      out_window_ok <= 1'b0;
      d_q           <= '0;
    end else begin
      out_valid     <= accept;
      out_window_ok <= accept & (line_base >= LINE_FULL);
      if (accept) begin
        out_col <= col_base;
        d_q     <= in_data;
      end
    end
  end

  assign taps_raw[tap_lo(0, DATA_WIDTH) +: DATA_WIDTH] = d_q;

  for (genvar k = 1; k < NUM_LINES; k++) begin : g_ram
    sdp_ram_1clk #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (LINE_MAX)
    ) u_ram (
      .clk     (clk),
      .we      (out_valid),
      .wr_addr (out_col),
      .wr_data (taps_raw[tap_lo(k-1, DATA_WIDTH) +: DATA_WIDTH]),
      .re      (accept),
      .rd_addr (col_base),
      .rd_data (taps_raw[tap_lo(k, DATA_WIDTH) +: DATA_WIDTH])
    );
  end

  assign out_taps = out_valid ? taps_raw : '0;

endmodule
